// File: rtl/key_debounce_array_if.sv
// rtl/key_debounce_array_if.sv - raw key inputs and conditioned key event outputs
interface key_debounce_array_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_rel;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_rpt;

  // conditioner side: samples the pins, produces levels and strobes
  modport master (
    input  key_in,
    output key_level,
    output key_press,
    output key_rel,
    output key_long,
    output key_rpt
  );

  // pin/consumer side: drives the pins, observes levels and strobes
  modport slave (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_rel,
    input  key_long,
    input  key_rpt
  );

endinterface

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - N-channel key synchroniser, debouncer, press/release/long/repeat strobes
module key_debounce_array #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 50000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  key_debounce_array_if.master  kif
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  // Compare values; every counter stops here and is cleared, so none ever wraps.
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic          RPT_EN    = (REPEAT_CYCLES > 0);

  // Raw pin value of a released key, loaded into the synchronisers on reset.
  localparam logic [N_KEYS-1:0] RELEASED_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] pol;
  logic [N_KEYS-1:0] db_done;
  logic [N_KEYS-1:0] accept_rise;
  logic [N_KEYS-1:0] accept_fall;

  logic [N_KEYS-1:0] level_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] rel_q;
  logic [N_KEYS-1:0] long_q;
  logic [N_KEYS-1:0] rpt_q;

  logic [CW-1:0] db_cnt [N_KEYS];
  logic [HW-1:0] hcnt   [N_KEYS];
  logic [1:0]    state  [N_KEYS];

  // Two-flop synchroniser per pin; reset parks every channel at "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RELEASED_RAW;
      sync2 <= RELEASED_RAW;
    end else begin
      sync1 <= kif.key_in;
      sync2 <= sync1;
    end
  end

  // Normalise polarity and detect the sample that completes a debounce run.
  always_comb begin
    pol     = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    db_done = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      db_done[i] = (pol[i] != level_q[i]) && (db_cnt[i] == DB_LAST);
    end
    accept_rise = db_done & pol;
    accept_fall = db_done & ~pol;
  end

  // Debounce counters, debounced level and the press/release strobes, which
  // are registered on the same edge as the level so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      press_q <= accept_rise;
      rel_q   <= accept_fall;
      level_q <= (level_q & ~accept_fall) | accept_rise;
      for (int i = 0; i < N_KEYS; i++) begin
        // any agreeing sample restarts the run, so short glitches never land
        if ((pol[i] == level_q[i]) || db_done[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Per-channel hold FSM producing the long-press and auto-repeat strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_q <= '0;
      rpt_q  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state[i] <= ST_IDLE;
        hcnt[i]  <= '0;
      end
    end else begin
      long_q <= '0;
      rpt_q  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (accept_fall[i]) begin
          // release beats a long/repeat due on the same edge
          state[i] <= ST_IDLE;
          hcnt[i]  <= '0;
        end else begin
          case (state[i])
            ST_IDLE: begin
              if (accept_rise[i]) begin
                state[i] <= ST_PRESS;
                hcnt[i]  <= '0;
              end
            end
            ST_PRESS: begin
              if (hcnt[i] == HOLD_LAST) begin
                long_q[i] <= 1'b1;
                state[i]  <= ST_HELD;
                hcnt[i]   <= '0;
              end else begin
                hcnt[i] <= hcnt[i] + 1'b1;
              end
            end
            ST_HELD: begin
              // with repeat disabled the counter simply parks at zero
              if (RPT_EN) begin
                if (hcnt[i] == RPT_LAST) begin
                  rpt_q[i] <= 1'b1;
                  hcnt[i]  <= '0;
                end else begin
                  hcnt[i] <= hcnt[i] + 1'b1;
                end
              end
            end
            default: begin
              state[i] <= ST_IDLE;
              hcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign kif.key_level = level_q;
  assign kif.key_press = press_q;
  assign kif.key_rel   = rel_q;
  assign kif.key_long  = long_q;
  assign kif.key_rpt   = rpt_q;

endmodule
